avr_fetch_unit: RTL
===================

// Module: avr_fetch_unit
// PURPOSE
//  Instruction fetch stage for the AVR core. Drives word addresses into program memory.
//  Absorbs the 1-cycle synchronous read latency. Presents one registered 16-bit
//  instruction per cycle, plus its 6-bit opcode field, to the control decode stage.
//  Handles decode-side stalls (1-entry skid buffer) and branch/jump redirects (flush).
// PARAMETERS
//  PC_WIDTH      10      word-address width; PC wraps modulo 2**PC_WIDTH
//  RESET_VECTOR  0       first word address fetched after reset
// PORTS
//  clk          in   1         rising-edge clock
//  rst_n        in   1         asynchronous active-low reset
//  imem_en      out  1         program memory read enable
//  imem_addr    out  PC_WIDTH  program memory word address
//  imem_data    in   16        read data, valid 1 cycle after imem_en
//  stall        in   1         decode not accepting; hold instr outputs
//  redirect     in   1         branch taken; discard in-flight words
//  redirect_pc  in   PC_WIDTH  new fetch address, sampled when redirect=1
//  instr        out  16        current instruction word (registered)
//  instr_pc     out  PC_WIDTH  word address of instr
//  instr_valid  out  1         instr is a real fetched word
//  opcode       out  6         instr[15:10], feeds control decode ROM
// BEHAVIOUR
//  Reset (async, rst_n=0): pc_q=RESET_VECTOR, pending_q=0, skid_valid_q=0,
//    instr=16'h0000 (nop), instr_pc=0, instr_valid=0, opcode=0, imem_en=0, state=BOOT.
//  FSM states: BOOT, RUN, HOLD, FLUSH.
//   BOOT : first clock after reset release. imem_en=0. -> RUN.
//   RUN  : imem_en=1 and imem_addr=pc_q when !stall && !redirect; pc_q<=pc_q+1.
//          pending_q<=issued. instr<=imem_data if pending_q, else instr_valid<=0.
//          stall -> HOLD. redirect -> FLUSH.
//   HOLD : no issue; imem_en=0; instr/instr_pc/instr_valid are held.
//          pending_q=1 on entry: imem_data -> skid_q, skid_valid_q<=1.
//          On stall=0: instr<=skid (if skid_valid_q), skid_valid_q<=0; issue pc_q. -> RUN.
//   FLUSH: entered the cycle after redirect. Issues redirect address (held in pc_q). -> RUN.
//  Redirect (any state, priority over stall):
//    pc_q<=redirect_pc; pending_q<=0; skid_valid_q<=0; instr_valid<=0; imem_en=0 that cycle.
//  Latency: address issue at cycle N -> instr valid at cycle N+2 (memory + output reg).
//    Redirect at cycle R -> first new instr_valid at R+3.
//  Skid depth 1 is sufficient: no issue while stalled, so at most one word is in flight.
//  Throughput: 1 instr/cycle in RUN with no stall.
//  PC wrap: 2**PC_WIDTH-1 + 1 -> 0, no flag.
//  Stall while instr_valid=0: legal; state is still held.
//  Stall and redirect in the same cycle: redirect wins; stall ignored.
//  Output invariants: opcode == instr[15:10] at all times.
//  Output invariants: instr_pc is the address that produced instr.
// STRUCTURE
//  defines.vh: add `FETCH_BOOT/RUN/HOLD/FLUSH (2-bit state codes) and `INSTR_NOP 16'h0000.
//  Sub-module: fetch_skid_buf (1-entry data+valid register: load, drain, clear).
//  The PC incrementer and FSM stay inline.
//  opcode is wired combinationally from the instr register to the control decode ROM.
// TESTING
//  1 Reset/boot: release rst_n, mem[i]=16'hE000|i
//    -> imem_en low for 1 cycle, then addr 0,1,2...
//    -> instr_valid first high 3 clks after release with instr=16'hE000, opcode=6'b111000.
//  2 Streaming: 8 cycles, no stall -> instr_pc 0..7 consecutive, one per cycle, no gaps.
//  3 Stall 3 cycles while word 4 is in flight
//    -> instr holds word 3 for all 3 cycles, imem_en=0.
//    -> after release: instr=word 4 (from skid), then 5,6 with no duplicate or skip.
//  4 Redirect to 0x100 at cycle R while stalled, skid full
//    -> instr_valid=0 for R+1..R+2.
//    -> instr_pc=0x100 at R+3; skid contents never appear at the output.
//  5 Wrap: PC_WIDTH=4, run from 14 -> instr_pc sequence 14,15,0,1.
//  6 Mid-operation reset: assert rst_n=0 during HOLD
//    -> outputs go to reset values asynchronously (before next clk edge).
//    -> on release, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/avr_fetch_unit_pkg.sv
// Shared types and constants for the AVR instruction fetch stage.
package avr_fetch_unit_pkg;

  // Fetch FSM: BOOT idles one clock after reset, RUN streams, HOLD waits out a decode
  // stall, FLUSH issues the redirect target.
  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StHold  = 2'd2,
    StFlush = 2'd3
  } fetch_state_e;

  localparam int unsigned InstrWidth  = 16;
  localparam int unsigned OpcodeWidth = 6;

  // All-zero word decodes as nop.
  localparam logic [InstrWidth-1:0] InstrNop = 16'h0000;

  // Major opcode field consumed by the control decode ROM.
  function automatic logic [OpcodeWidth-1:0] opcode_field(input logic [InstrWidth-1:0] word);
    return word[15:10];
  endfunction

endpackage

// File: rtl/avr_fetch_unit_skid_buf.sv
// One-entry data+valid holding register for the word that lands while decode is stalled.
module avr_fetch_unit_skid_buf #(
  parameter int unsigned Width = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic             clear,
  input  logic [Width-1:0] load_data,
  output logic [Width-1:0] data,
  output logic             valid
);

  logic [Width-1:0] data_q;
  logic             valid_q;

  // Clear beats load beats drain; data is only meaningful while valid is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= load_data;
      valid_q <= 1'b1;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/avr_fetch_unit.sv
// AVR instruction fetch stage: drives program memory, hides its 1-cycle read latency,
// absorbs decode stalls with a 1-entry skid and discards in-flight words on redirect.
module avr_fetch_unit
  import avr_fetch_unit_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = 10,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [InstrWidth-1:0]  imem_data,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [InstrWidth-1:0]  instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  output logic [OpcodeWidth-1:0] opcode
);

  localparam int unsigned SkidWidth = PC_WIDTH + InstrWidth;

  fetch_state_e state_q, state_d;

  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  pending_q, pending_d;
  logic [PC_WIDTH-1:0]   pend_pc_q, pend_pc_d;     // address of the word now on imem_data
  logic [InstrWidth-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]   instr_pc_q, instr_pc_d;
  logic                  instr_valid_q, instr_valid_d;

  logic                  issue;
  logic                  skid_load, skid_drain, skid_clear;
  logic                  skid_valid;
  logic [SkidWidth-1:0]  skid_data;

  // Skid keeps the word together with its address so instr_pc stays truthful.
  avr_fetch_unit_skid_buf #(
    .Width(SkidWidth)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .drain    (skid_drain),
    .clear    (skid_clear),
    .load_data({pend_pc_q, imem_data}),
    .data     (skid_data),
    .valid    (skid_valid)
  );

  // Next-state, issue and output-register logic; redirect overrides everything else.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_d     = 1'b0;
    pend_pc_d     = pend_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    issue         = 1'b0;
    skid_load     = 1'b0;
    skid_drain    = 1'b0;
    skid_clear    = 1'b0;

    if (redirect) begin
      state_d       = StFlush;
      pc_d          = redirect_pc;
      skid_clear    = 1'b1;
      instr_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StBoot: state_d = StRun;
        StRun: begin
          if (stall) begin
            // Nothing new is issued, so the only word that can still land is this one.
            state_d   = StHold;
            skid_load = pending_q;
          end else begin
            issue = 1'b1;
            if (pending_q) begin
              instr_d       = imem_data;
              instr_pc_d    = pend_pc_q;
              instr_valid_d = 1'b1;
            end else begin
              instr_valid_d = 1'b0;
            end
          end
        end
        StHold: begin
          if (!stall) begin
            state_d    = StRun;
            issue      = 1'b1;
            skid_drain = 1'b1;
            if (skid_valid) begin
              instr_d       = skid_data[InstrWidth-1:0];
              instr_pc_d    = skid_data[SkidWidth-1:InstrWidth];
              instr_valid_d = 1'b1;
            end else begin
              instr_valid_d = 1'b0;
            end
          end
        end
        StFlush: begin
          state_d = StRun;
          issue   = 1'b1;
        end
        default: state_d = StBoot;
      endcase
    end

    if (issue) begin
      pc_d      = pc_q + PC_WIDTH'(1);
      pending_d = 1'b1;
      pend_pc_d = pc_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_VECTOR;
      pending_q     <= 1'b0;
      pend_pc_q     <= '0;
      instr_q       <= InstrNop;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_q     <= pending_d;
      pend_pc_q     <= pend_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_en     = issue;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = opcode_field(instr_q);

endmodule
